// File: rtl/trap_entry_sequencer_pkg.sv
// Shared trap-type, register-number and sequencer state definitions for the
// trap-entry path and the branch/trap condition tester.
package trap_entry_sequencer_pkg;

  localparam logic [7:0] TT_ILLEGAL   = 8'h02;
  localparam logic [7:0] TT_PRIV      = 8'h03;
  localparam logic [7:0] TT_WOVF      = 8'h05;
  localparam logic [7:0] TT_WUNF      = 8'h06;
  localparam logic [7:0] TT_TICC_BASE = 8'h80;

  localparam logic [4:0] RF_R17 = 5'd17;
  localparam logic [4:0] RF_R18 = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_SAVE_PC,
    ST_SAVE_NPC,
    ST_VECTOR,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/trap_entry_sequencer_prio_enc.sv
// Combinational trap prioritisation: merges hardware exceptions and Ticc into
// one request and the single highest-priority trap type.
module trap_priority_encoder
  import trap_entry_sequencer_pkg::*;
(
  input  logic       illegal_inst,
  input  logic       priv_inst,
  input  logic       win_overflow,
  input  logic       win_underflow,
  input  logic       tcond,
  input  logic [6:0] sw_tt,
  output logic       req,
  output logic [7:0] tt
);

  always_comb begin
    req = illegal_inst | priv_inst | win_overflow | win_underflow | tcond;
    tt  = 8'h00;
    if (illegal_inst)       tt = TT_ILLEGAL;
    else if (priv_inst)     tt = TT_PRIV;
    else if (win_overflow)  tt = TT_WOVF;
    else if (win_underflow) tt = TT_WUNF;
    else if (tcond)         tt = TT_TICC_BASE | {1'b0, sw_tt};
  end

endmodule

// File: rtl/trap_entry_sequencer.sv
// SPARC V8 trap-entry sequencer: records the trap context, then steps through
// PSR/TBR update, r17/r18 saves and the fetch redirect while stalling upstream.
module trap_entry_sequencer
  import trap_entry_sequencer_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tcond,
  input  logic [6:0]       sw_tt,
  input  logic             illegal_inst,
  input  logic             priv_inst,
  input  logic             win_overflow,
  input  logic             win_underflow,
  input  logic             psr_et,
  input  logic             psr_s,
  input  logic [CWP_W-1:0] psr_cwp,
  input  logic [19:0]      tbr_tba,
  input  logic [31:0]      pc,
  input  logic [31:0]      npc,
  output logic             stall,
  output logic             psr_we,
  output logic             psr_et_new,
  output logic             psr_ps_new,
  output logic             psr_s_new,
  output logic [CWP_W-1:0] psr_cwp_new,
  output logic             tbr_tt_we,
  output logic [7:0]       tbr_tt,
  output logic             rf_we,
  output logic [CWP_W-1:0] rf_cwp,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             error_mode
);

  logic             req;
  logic [7:0]       tt_enc;
  logic [CWP_W-1:0] cwp_dec;

  state_e           state_q, state_d;
  logic [7:0]       tt_q, tt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic [19:0]      tba_q, tba_d;
  logic             s_q, s_d;
  logic [CWP_W-1:0] cwp_q, cwp_d;

  trap_priority_encoder u_prio (
    .illegal_inst (illegal_inst),
    .priv_inst    (priv_inst),
    .win_overflow (win_overflow),
    .win_underflow(win_underflow),
    .tcond        (tcond),
    .sw_tt        (sw_tt),
    .req          (req),
    .tt           (tt_enc)
  );

  // The trap window is the one below the current CWP, wrapping at window 0.
  assign cwp_dec = (psr_cwp == '0) ? CWP_W'(NWINDOWS - 1) : psr_cwp - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tt_q    <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      tba_q   <= '0;
      s_q     <= 1'b0;
      cwp_q   <= '0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      tba_q   <= tba_d;
      s_q     <= s_d;
      cwp_q   <= cwp_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tt_d           = tt_q;
    pc_d           = pc_q;
    npc_d          = npc_q;
    tba_d          = tba_q;
    s_d            = s_q;
    cwp_d          = cwp_q;
    stall          = 1'b1;
    psr_we         = 1'b0;
    psr_et_new     = 1'b0;
    psr_ps_new     = 1'b0;
    psr_s_new      = 1'b0;
    psr_cwp_new    = '0;
    tbr_tt_we      = 1'b0;
    tbr_tt         = '0;
    rf_we          = 1'b0;
    rf_cwp         = '0;
    rf_addr        = '0;
    rf_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    error_mode     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
        if (req) begin
          if (psr_et) begin
            tt_d    = tt_enc;
            pc_d    = pc;
            npc_d   = npc;
            tba_d   = tbr_tba;
            s_d     = psr_s;
            cwp_d   = cwp_dec;
            state_d = ST_ENTER;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ENTER: begin
        psr_we      = 1'b1;
        psr_ps_new  = s_q;
        psr_s_new   = 1'b1;
        psr_cwp_new = cwp_q;
        tbr_tt_we   = 1'b1;
        tbr_tt      = tt_q;
        state_d     = ST_SAVE_PC;
      end
      ST_SAVE_PC: begin
        rf_we   = 1'b1;
        rf_cwp  = cwp_q;
        rf_addr = RF_R17;
        rf_data = pc_q;
        state_d = ST_SAVE_NPC;
      end
      ST_SAVE_NPC: begin
        rf_we   = 1'b1;
        rf_cwp  = cwp_q;
        rf_addr = RF_R18;
        rf_data = npc_q;
        state_d = ST_VECTOR;
      end
      ST_VECTOR: begin
        redirect_valid = 1'b1;
        redirect_pc    = {tba_q, tt_q, 4'b0000};
        state_d        = ST_IDLE;
      end
      ST_ERROR: begin
        error_mode = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Directed bench for trap_entry_sequencer: a table of trap scenarios with
// hand-computed results, plus back-to-back, error-mode and abort sequences.
module tb_trap_entry_sequencer;

  typedef struct {
    logic        illegal;
    logic        priv;
    logic        ovf;
    logic        unf;
    logic        tc;
    logic [6:0]  swtt;
    logic        s;
    logic [4:0]  cwp;
    logic [19:0] tba;
    logic [31:0] pcv;
    logic [31:0] npcv;
    logic [7:0]  exp_tt;
    logic [4:0]  exp_cwp;
    logic [31:0] exp_redir;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tcond, illegal_inst, priv_inst, win_overflow, win_underflow;
  logic [6:0]  sw_tt;
  logic        psr_et, psr_s;
  logic [4:0]  psr_cwp;
  logic [19:0] tbr_tba;
  logic [31:0] pc, npc;
  logic        stall, psr_we, psr_et_new, psr_ps_new, psr_s_new;
  logic [4:0]  psr_cwp_new;
  logic        tbr_tt_we;
  logic [7:0]  tbr_tt;
  logic        rf_we;
  logic [4:0]  rf_cwp, rf_addr;
  logic [31:0] rf_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        error_mode;

  int n_vec  = 0;
  int n_fail = 0;
  int rf_cnt = 0, psr_cnt = 0, redir_cnt = 0;

  vec_t vecs[6];

  trap_entry_sequencer #(.NWINDOWS(8), .CWP_W(5)) dut (
    .clk(clk), .reset(reset), .tcond(tcond), .sw_tt(sw_tt),
    .illegal_inst(illegal_inst), .priv_inst(priv_inst),
    .win_overflow(win_overflow), .win_underflow(win_underflow),
    .psr_et(psr_et), .psr_s(psr_s), .psr_cwp(psr_cwp), .tbr_tba(tbr_tba),
    .pc(pc), .npc(npc), .stall(stall), .psr_we(psr_we),
    .psr_et_new(psr_et_new), .psr_ps_new(psr_ps_new), .psr_s_new(psr_s_new),
    .psr_cwp_new(psr_cwp_new), .tbr_tt_we(tbr_tt_we), .tbr_tt(tbr_tt),
    .rf_we(rf_we), .rf_cwp(rf_cwp), .rf_addr(rf_addr), .rf_data(rf_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we)          rf_cnt++;
    if (psr_we)         psr_cnt++;
    if (redirect_valid) redir_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic il, input logic pr, input logic ov, input logic un,
                              input logic tc, input logic [6:0] swtt, input logic s,
                              input logic [4:0] cwp, input logic [19:0] tba,
                              input logic [31:0] pcv, input logic [31:0] npcv,
                              input logic [7:0] ett, input logic [4:0] ecwp,
                              input logic [31:0] eredir);
    vec_t v;
    v.illegal = il; v.priv = pr; v.ovf = ov; v.unf = un; v.tc = tc; v.swtt = swtt;
    v.s = s; v.cwp = cwp; v.tba = tba; v.pcv = pcv; v.npcv = npcv;
    v.exp_tt = ett; v.exp_cwp = ecwp; v.exp_redir = eredir;
    return v;
  endfunction

  function automatic logic any_out();
    return |{stall, psr_we, psr_et_new, psr_ps_new, psr_s_new, psr_cwp_new, tbr_tt_we,
             tbr_tt, rf_we, rf_cwp, rf_addr, rf_data, redirect_valid, redirect_pc, error_mode};
  endfunction

  task automatic clear_src();
    tcond = 0; illegal_inst = 0; priv_inst = 0; win_overflow = 0; win_underflow = 0;
    psr_et = 1;
  endtask

  task automatic drive_vec(input vec_t v);
    illegal_inst = v.illegal; priv_inst = v.priv; win_overflow = v.ovf;
    win_underflow = v.unf; tcond = v.tc; sw_tt = v.swtt; psr_et = 1'b1;
    psr_s = v.s; psr_cwp = v.cwp; tbr_tba = v.tba; pc = v.pcv; npc = v.npcv;
  endtask

  // Upstream noise while the sequencer is busy; all of it must be ignored.
  task automatic garbage();
    pc = $urandom; npc = $urandom; tbr_tba = 20'($urandom);
    psr_cwp = 5'($urandom_range(0, 7)); psr_s = ~psr_s; sw_tt = 7'($urandom);
    tcond = 1; illegal_inst = 1; win_underflow = 1; psr_et = 1'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input bit immediate, input bit toggle);
    int rf0, psr0, rd0;
    if (!immediate) @(posedge clk);
    #1;
    rf0 = rf_cnt; psr0 = psr_cnt; rd0 = redir_cnt;
    drive_vec(v);
    @(posedge clk); #1;
    if (toggle) garbage(); else clear_src();
    @(negedge clk);
    chk("enter_stall", stall, 1);
    chk("enter_psr_we", psr_we, 1);
    chk("enter_et", psr_et_new, 0);
    chk("enter_ps", psr_ps_new, v.s);
    chk("enter_s", psr_s_new, 1);
    chk("enter_cwp", psr_cwp_new, v.exp_cwp);
    chk("enter_tt_we", tbr_tt_we, 1);
    chk("enter_tt", tbr_tt, v.exp_tt);
    chk("enter_rf_we", rf_we, 0);
    @(posedge clk); #1;
    if (toggle) garbage();
    @(negedge clk);
    chk("r17_we", rf_we, 1);
    chk("r17_cwp", rf_cwp, v.exp_cwp);
    chk("r17_addr", rf_addr, 17);
    chk("r17_data", rf_data, v.pcv);
    chk("r17_psr_we", psr_we, 0);
    chk("r17_tt", tbr_tt, 0);
    @(posedge clk); #1;
    if (toggle) garbage();
    @(negedge clk);
    chk("r18_we", rf_we, 1);
    chk("r18_cwp", rf_cwp, v.exp_cwp);
    chk("r18_addr", rf_addr, 18);
    chk("r18_data", rf_data, v.npcv);
    @(posedge clk); #1;
    clear_src();
    @(negedge clk);
    chk("vec_valid", redirect_valid, 1);
    chk("vec_pc", redirect_pc, v.exp_redir);
    chk("vec_rf_we", rf_we, 0);
    chk("vec_rf_data", rf_data, 0);
    chk("vec_stall", stall, 1);
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_outs", any_out(), 0);
    chk("rf_writes", rf_cnt - rf0, 2);
    chk("psr_writes", psr_cnt - psr0, 1);
    chk("redirects", redir_cnt - rd0, 1);
  endtask

  initial begin
    int rf0, psr0, rd0;
    vecs[0] = mk(0,0,0,0,1, 7'h05, 0, 5'd3, 20'h40000, 32'h1000, 32'h1004, 8'h85, 5'd2, 32'h4000_0850);
    vecs[1] = mk(0,0,1,0,0, 7'h00, 1, 5'd0, 20'h12345, 32'h2000, 32'h2004, 8'h05, 5'd7, 32'h1234_5050);
    vecs[2] = mk(1,0,0,1,1, 7'h7f, 0, 5'd5, 20'hABCDE, 32'h3000, 32'h3004, 8'h02, 5'd4, 32'hABCD_E020);
    vecs[3] = mk(0,1,1,0,0, 7'h00, 1, 5'd1, 20'h00001, 32'h4000, 32'h4008, 8'h03, 5'd0, 32'h0000_1030);
    vecs[4] = mk(0,0,0,1,1, 7'h00, 0, 5'd7, 20'hFFFFF, 32'hFFFF_FFFC, 32'h0, 8'h06, 5'd6, 32'hFFFF_F060);
    vecs[5] = mk(0,0,0,0,1, 7'h7f, 1, 5'd2, 20'h00000, 32'h5000, 32'h5004, 8'hFF, 5'd1, 32'h0000_0FF0);

    reset = 1; clear_src(); psr_s = 0; psr_cwp = 0; sw_tt = 0; tbr_tba = 0; pc = 0; npc = 0;
    #2;
    chk("reset_outs", any_out(), 0);
    @(negedge clk); #2 reset = 0;
    @(negedge clk);
    chk("idle_stall", stall, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 1'b0);

    // Back-to-back: second request present in the first idle cycle.
    run_vec(vecs[0], 1'b0, 1'b1);
    run_vec(vecs[1], 1'b1, 1'b1);

    // ET=0 trap -> sticky error mode.
    @(posedge clk); #1;
    psr_et = 0; priv_inst = 1;
    rf0 = rf_cnt; psr0 = psr_cnt; rd0 = redir_cnt;
    @(posedge clk); #1;
    priv_inst = 0; psr_et = 1; tcond = 1;
    @(negedge clk);
    chk("err_mode", error_mode, 1);
    chk("err_tt_we", tbr_tt_we, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("err_hold", {error_mode, stall}, 2'b11);
    end
    chk("err_rf", rf_cnt - rf0, 0);
    chk("err_psr", psr_cnt - psr0, 0);
    chk("err_redir", redir_cnt - rd0, 0);
    #2 reset = 1;
    #1 chk("err_reset", any_out(), 0);
    clear_src();
    @(negedge clk); #2 reset = 0;
    @(negedge clk);
    chk("err_idle", stall, 0);

    // Reset during SAVE_PC aborts the sequence.
    @(posedge clk); #1;
    drive_vec(vecs[1]);
    @(posedge clk); #1;
    clear_src();
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_r17", rf_we, 1);
    #2 reset = 1;
    #1 chk("abort_outs", any_out(), 0);
    rf0 = rf_cnt; rd0 = redir_cnt;
    @(negedge clk); #2 reset = 0;
    repeat (6) @(negedge clk);
    chk("abort_rf", rf_cnt - rf0, 0);
    chk("abort_redir", redir_cnt - rd0, 0);
    chk("abort_idle", any_out(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_entry_sequencer.md
Name: trap_entry_sequencer

Overview:
- Consumes TCOND from the branch/trap condition tester, plus synchronous hardware exception flags from decode.
- Runs the SPARC V8 trap-entry sequence:
  - prioritise the trap and set TBR.tt;
  - update PSR (ET, PS, S, CWP);
  - save PC/nPC into r17/r18 of the new window;
  - redirect fetch to the trap vector.
- Sits between decode/condition test and the PSR, TBR, register file and fetch PC mux; stalls the pipeline while sequencing.

Parameters:
NWINDOWS, 8, number of register windows; CWP wraps modulo NWINDOWS (legal 2..32)
CWP_W, 5, width of the CWP field

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
tcond  in  1  Ticc condition true (from condition tester)
sw_tt  in  7  Ticc trap number, (rs1 + rs2/simm13)[6:0]
illegal_inst  in  1  illegal_instruction exception
priv_inst  in  1  privileged_instruction exception
win_overflow  in  1  window_overflow exception
win_underflow  in  1  window_underflow exception
psr_et  in  1  current PSR.ET
psr_s  in  1  current PSR.S
psr_cwp  in  CWP_W  current PSR.CWP
tbr_tba  in  20  TBR[31:12]
pc  in  32  PC of the trapping instruction
npc  in  32  nPC of the trapping instruction
stall  out  1  freeze fetch/decode
psr_we  out  1  PSR field write strobe
psr_et_new  out  1  new ET
psr_ps_new  out  1  new PS
psr_s_new  out  1  new S
psr_cwp_new  out  CWP_W  new CWP
tbr_tt_we  out  1  TBR.tt write strobe
tbr_tt  out  8  trap type
rf_we  out  1  register-file write strobe
rf_cwp  out  CWP_W  window used for the rf write
rf_addr  out  5  register number (17 or 18)
rf_data  out  32  data to write
redirect_valid  out  1  load fetch PC with redirect_pc
redirect_pc  out  32  trap vector address
error_mode  out  1  processor in error mode (sticky)

Behaviour:
- Reset: state=IDLE. Every output is 0, including error_mode. All latched registers are cleared. Reset asserted mid-sequence aborts it immediately, and no partial strobes fire after deassertion.
- States: IDLE, ENTER, SAVE_PC, SAVE_NPC, VECTOR, ERROR. All outputs are registered, or decoded from state plus latched registers; no input reaches an output combinationally.
- Trap request: req = illegal_inst | priv_inst | win_overflow | win_underflow | tcond.
- Priority and tt, highest first:
  - illegal 8'h02
  - priv 8'h03
  - overflow 8'h05
  - underflow 8'h06
  - Ticc {1'b1, sw_tt}
  Simultaneous sources produce exactly one trap, using the highest-priority tt.
- IDLE, req=1, psr_et=1:
  - latch tt, pc, npc, psr_s;
  - latch new_cwp = (psr_cwp==0) ? NWINDOWS-1 : psr_cwp-1;
  - go to ENTER.
- IDLE, req=1, psr_et=0: go to ERROR. Nothing else is latched and no strobe fires.
- ENTER (1 cycle):
  - psr_we=1, psr_et_new=0, psr_ps_new=latched S, psr_s_new=1, psr_cwp_new=new_cwp;
  - tbr_tt_we=1, tbr_tt=tt;
  - go to SAVE_PC.
- SAVE_PC: rf_we=1, rf_cwp=new_cwp, rf_addr=17, rf_data=latched pc; go to SAVE_NPC.
- SAVE_NPC: rf_we=1, rf_cwp=new_cwp, rf_addr=18, rf_data=latched npc; go to VECTOR.
- VECTOR: redirect_valid=1, redirect_pc={tbr_tba, tt, 4'b0000}; go to IDLE.
- ERROR: error_mode=1 and stall=1 permanently; leaves only via reset.
- stall=1 in every state except IDLE.
- Latency: request sampled at edge N:
  - ENTER strobes valid in cycle N+1;
  - r17 write in N+2, r18 write in N+3;
  - redirect in N+4;
  - stall drops in N+5.
  A request present in cycle N+5 starts a new trap immediately.
- Requests while not in IDLE are ignored, since upstream is stalled. Input changes mid-sequence never alter latched values.
- Strobes (psr_we, tbr_tt_we, rf_we, redirect_valid) are single-cycle pulses. Data outputs are 0 whenever their strobe is 0.

Decomposition:
- Shared package (with condition-tester constants):
  - TT_ILLEGAL=8'h02, TT_PRIV=8'h03, TT_WOVF=8'h05, TT_WUNF=8'h06, TT_TICC_BASE=8'h80;
  - state enum;
  - RF_R17=5'd17, RF_R18=5'd18.
- One natural sub-module: trap_priority_encoder. It is combinational; sources plus sw_tt in, req and tt out.

Test Plan:
- tcond=1, sw_tt=7'h05, ET=1, S=0, CWP=3, TBA=20'h40000, pc=32'h1000, npc=32'h1004:
  - N+1: psr_we, ET=0, PS=0, S=1, CWP=2, tt=8'h85;
  - N+2: r17=32'h1000; N+3: r18=32'h1004;
  - N+4: redirect_pc=32'h4000_0850.
- CWP=0, NWINDOWS=8, win_overflow=1 -> psr_cwp_new=7, tbr_tt=8'h05, rf_cwp=7 on both writes.
- illegal_inst=1, tcond=1 and win_underflow=1 in the same cycle -> single sequence, tt=8'h02, exactly 2 rf writes.
- ET=0, priv_inst=1 -> ERROR next cycle. error_mode=1 and stall=1 hold for 20 cycles; no psr_we/rf_we/redirect ever; reset clears error_mode.
- reset asserted during SAVE_PC -> all outputs 0 asynchronously, no r18 write and no redirect after release, state IDLE.
- Back-to-back: second trap requested in N+5 -> new ENTER at N+6. Inputs toggled during N+1..N+4 do not change rf_data or redirect_pc.
